// File: rtl/battleship_pkg.sv
// Shared battleship constants: tile, opcode and response encodings plus board
// geometry. The tile renderer decodes the same tile constants.
package battleship_pkg;

  localparam int BOARD_DIM  = 10;
  localparam int SHIP_CELLS = 17;

  localparam logic [4:0] COORD_MAX  = 5'(BOARD_DIM - 1);
  localparam logic [4:0] HITS_MAX   = 5'(SHIP_CELLS);
  localparam logic [6:0] CLEAR_LAST = 7'(BOARD_DIM * BOARD_DIM - 1);

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_HIT   = 2'd1,
    TILE_MISS  = 2'd2,
    TILE_SHIP  = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_PLACE = 2'd1,
    OP_FIRE  = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    RESP_OK     = 2'd0,
    RESP_HIT    = 2'd1,
    RESP_MISS   = 2'd2,
    RESP_REJECT = 2'd3
  } resp_t;

  // How the board cursor advances on each step
  typedef enum logic [1:0] {
    STEP_X      = 2'd0,
    STEP_Y      = 2'd1,
    STEP_RASTER = 2'd2
  } step_mode_t;

  // Coordinates are widened to 5 bits so end-of-ship sums never wrap
  function automatic logic off_board(input logic [4:0] c);
    return c > COORD_MAX;
  endfunction

endpackage

// File: rtl/board_updater_if.sv
// Command, response and RAM write-port bundle of the board updater.
// slave is the updater's view; master is the command initiator / RAM side.
interface board_updater_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [2:0] cmd_len;
  logic       cmd_vert;

  logic [9:0] ram_addr;
  logic       ram_we;
  logic [1:0] ram_wdata;
  logic [1:0] ram_rdata;

  logic       resp_valid;
  logic [1:0] resp_code;
  logic [4:0] hit_count;
  logic       all_sunk;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_vert, ram_rdata,
    output cmd_ready, ram_addr, ram_we, ram_wdata,
    output resp_valid, resp_code, hit_count, all_sunk
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_vert, ram_rdata,
    input  cmd_ready, ram_addr, ram_we, ram_wdata,
    input  resp_valid, resp_code, hit_count, all_sunk
  );

endinterface

// File: rtl/board_coord_step.sv
// Board cursor shared by CLEAR, the PLACE overlap check and the PLACE write.
// Holds x/y plus a remaining-tile count; the registered x/y is the RAM address.
module board_coord_step
  import battleship_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [4:0] i_x,
  input  logic [4:0] i_y,
  input  logic [6:0] i_cnt,
  input  step_mode_t i_mode,
  output logic [9:0] o_addr,
  output logic       o_last
);

  logic [4:0] r_x;
  logic [4:0] r_y;
  logic [6:0] r_cnt;
  step_mode_t r_mode;

  // Load a start tile and tile budget, then advance one tile per step
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_mode <= STEP_X;
    end else if (i_load) begin
      r_x    <= i_x;
      r_y    <= i_y;
      r_cnt  <= i_cnt;
      r_mode <= i_mode;
    end else if (i_step) begin
      r_cnt <= r_cnt - 7'd1;
      case (r_mode)
        STEP_Y: r_y <= r_y + 5'd1;
        STEP_RASTER: begin
          if (r_x == COORD_MAX) begin
            r_x <= '0;
            r_y <= r_y + 5'd1;
          end else begin
            r_x <= r_x + 5'd1;
          end
        end
        default: r_x <= r_x + 5'd1;
      endcase
    end
  end

  assign o_addr = {r_x, r_y};
  assign o_last = (r_cnt == 7'd0);

endmodule

// File: rtl/board_updater.sv
// Write-side engine for one player's board RAM: CLEAR, PLACE and FIRE
// commands run as read-check-write sequences, one response per command.
module board_updater
  import battleship_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  board_updater_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, CLR, CHK_RD, CHK_EV, PL_WR, F_RD, F_WAIT, F_EV, RESP
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_ram_we, w_ram_we_nxt;
  logic [1:0] r_ram_wdata, w_ram_wdata_nxt;
  logic       r_resp_valid;
  logic [1:0] r_resp_code, w_resp_code_nxt;
  logic [4:0] r_hit_count;
  logic       w_hit_clr, w_hit_inc;

  logic [3:0] r_x, r_y;
  logic [2:0] r_len;
  logic       r_vert;

  logic       w_accept;
  logic [4:0] w_cx, w_cy, w_len5, w_end;
  logic       w_place_bad, w_fire_bad;

  logic       w_ld, w_step, w_last;
  logic [4:0] w_ld_x, w_ld_y;
  logic [6:0] w_ld_cnt;
  step_mode_t w_ld_mode;
  logic [9:0] w_addr;

  assign w_accept = bus.cmd_valid && (r_state == IDLE);

  assign w_cx   = {1'b0, bus.cmd_x};
  assign w_cy   = {1'b0, bus.cmd_y};
  assign w_len5 = {2'b00, bus.cmd_len};
  assign w_end  = (bus.cmd_vert ? w_cy : w_cx) + w_len5 - 5'd1;

  assign w_fire_bad  = off_board(w_cx) || off_board(w_cy);
  assign w_place_bad = (bus.cmd_len < 3'd2) || (bus.cmd_len > 3'd5) ||
                       w_fire_bad || off_board(w_end);

  board_coord_step u_step (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_ld),
    .i_step  (w_step),
    .i_x     (w_ld_x),
    .i_y     (w_ld_y),
    .i_cnt   (w_ld_cnt),
    .i_mode  (w_ld_mode),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, cursor control and next values of the registered outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_ram_we_nxt    = 1'b0;
    w_ram_wdata_nxt = TILE_EMPTY;
    w_resp_code_nxt = r_resp_code;
    w_hit_clr       = 1'b0;
    w_hit_inc       = 1'b0;
    w_ld            = 1'b0;
    w_step          = 1'b0;
    w_ld_x          = w_cx;
    w_ld_y          = w_cy;
    w_ld_cnt        = '0;
    w_ld_mode       = STEP_X;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_CLEAR: begin
              w_ld         = 1'b1;
              w_ld_x       = '0;
              w_ld_y       = '0;
              w_ld_cnt     = CLEAR_LAST;
              w_ld_mode    = STEP_RASTER;
              w_ram_we_nxt = 1'b1;
              w_hit_clr    = 1'b1;
              w_state_nxt  = CLR;
            end
            OP_PLACE: begin
              if (w_place_bad) begin
                w_resp_code_nxt = RESP_REJECT;
                w_state_nxt     = RESP;
              end else begin
                w_ld        = 1'b1;
                w_ld_cnt    = {4'b0000, bus.cmd_len - 3'd1};
                w_ld_mode   = bus.cmd_vert ? STEP_Y : STEP_X;
                w_state_nxt = CHK_RD;
              end
            end
            OP_FIRE: begin
              if (w_fire_bad) begin
                w_resp_code_nxt = RESP_REJECT;
                w_state_nxt     = RESP;
              end else begin
                w_ld        = 1'b1;
                w_state_nxt = F_RD;
              end
            end
            default: begin
              w_resp_code_nxt = RESP_REJECT;
              w_state_nxt     = RESP;
            end
          endcase
        end
      end
      CLR: begin
        if (w_last) begin
          w_resp_code_nxt = RESP_OK;
          w_state_nxt     = RESP;
        end else begin
          w_step       = 1'b1;
          w_ram_we_nxt = 1'b1;
        end
      end
      CHK_RD: w_state_nxt = CHK_EV;
      CHK_EV: begin
        if (bus.ram_rdata != TILE_EMPTY) begin
          w_resp_code_nxt = RESP_REJECT;
          w_state_nxt     = RESP;
        end else if (w_last) begin
          // Rewind the cursor to the ship's first tile for the write pass
          w_ld            = 1'b1;
          w_ld_x          = {1'b0, r_x};
          w_ld_y          = {1'b0, r_y};
          w_ld_cnt        = {4'b0000, r_len - 3'd1};
          w_ld_mode       = r_vert ? STEP_Y : STEP_X;
          w_ram_we_nxt    = 1'b1;
          w_ram_wdata_nxt = TILE_SHIP;
          w_state_nxt     = PL_WR;
        end else begin
          w_step      = 1'b1;
          w_state_nxt = CHK_RD;
        end
      end
      PL_WR: begin
        if (w_last) begin
          w_resp_code_nxt = RESP_OK;
          w_state_nxt     = RESP;
        end else begin
          w_step          = 1'b1;
          w_ram_we_nxt    = 1'b1;
          w_ram_wdata_nxt = TILE_SHIP;
        end
      end
      F_RD:   w_state_nxt = F_WAIT;
      F_WAIT: w_state_nxt = F_EV;
      F_EV: begin
        w_state_nxt = RESP;
        case (bus.ram_rdata)
          TILE_SHIP: begin
            w_ram_we_nxt    = 1'b1;
            w_ram_wdata_nxt = TILE_HIT;
            w_resp_code_nxt = RESP_HIT;
            w_hit_inc       = 1'b1;
          end
          TILE_EMPTY: begin
            w_ram_we_nxt    = 1'b1;
            w_ram_wdata_nxt = TILE_MISS;
            w_resp_code_nxt = RESP_MISS;
          end
          default: w_resp_code_nxt = RESP_REJECT;
        endcase
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered RAM strobe/data and response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= TILE_EMPTY;
      r_resp_valid <= 1'b0;
      r_resp_code  <= RESP_OK;
    end else begin
      r_ram_we     <= w_ram_we_nxt;
      r_ram_wdata  <= w_ram_wdata_nxt;
      r_resp_valid <= (w_state_nxt == RESP);
      r_resp_code  <= w_resp_code_nxt;
    end
  end

  // Command fields kept for the PLACE write pass after the overlap check
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_len  <= '0;
      r_vert <= 1'b0;
    end else if (w_accept) begin
      r_x    <= bus.cmd_x;
      r_y    <= bus.cmd_y;
      r_len  <= bus.cmd_len;
      r_vert <= bus.cmd_vert;
    end
  end

  // Saturating hit counter, zeroed when a CLEAR is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_count <= '0;
    end else if (w_hit_clr) begin
      r_hit_count <= '0;
    end else if (w_hit_inc && (r_hit_count != HITS_MAX)) begin
      r_hit_count <= r_hit_count + 5'd1;
    end
  end

  assign bus.cmd_ready  = (r_state == IDLE);
  assign bus.ram_addr   = w_addr;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_code  = r_resp_code;
  assign bus.hit_count  = r_hit_count;
  assign bus.all_sunk   = (r_hit_count == HITS_MAX);

endmodule

// File: tb/tb_board_updater.sv
// Directed bench for board_updater: a RAM model behind the write port and
// queues of expected writes/responses, each tagged with its cycle offset.
module tb_board_updater;
  import battleship_pkg::*;

  typedef struct {
    logic [9:0] addr;
    logic [1:0] data;
    int         lat;
  } wrExp_t;

  typedef struct {
    logic [1:0] code;
    int         lat;
  } respExp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  board_updater_if bus ();

  board_updater dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  wrExp_t     wrQ[$];
  respExp_t   respQ[$];
  logic [9:0] shipTiles[$];
  logic [1:0] mem [0:1023];
  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;
  int acceptCycle = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  // Cycle counter used to time writes and responses relative to accept
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Synchronous RAM with one-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop expected writes and responses as the DUT produces them
  always @(negedge clk) begin
    wrExp_t   we;
    respExp_t re;
    if (bus.ram_we === 1'b1) begin
      assertCount++;
      assert (wrQ.size() != 0) else begin
        failCount++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", bus.ram_addr, bus.ram_wdata);
      end
      if (wrQ.size() != 0) begin
        we = wrQ.pop_front();
        checkOutput("wr_addr", 32'(bus.ram_addr), 32'(we.addr));
        checkOutput("wr_data", 32'(bus.ram_wdata), 32'(we.data));
        checkOutput("wr_cycle", 32'(cycleNo - acceptCycle), 32'(we.lat));
      end
    end
    if (bus.resp_valid === 1'b1) begin
      assertCount++;
      assert (respQ.size() != 0) else begin
        failCount++;
        $error("FAIL unexpected_resp: observed code %0h expected no response", bus.resp_code);
      end
      if (respQ.size() != 0) begin
        re = respQ.pop_front();
        checkOutput("resp_code", 32'(bus.resp_code), 32'(re.code));
        checkOutput("resp_cycle", 32'(cycleNo - acceptCycle), 32'(re.lat));
      end
    end
  end

  function automatic logic [9:0] addrOf(input int x, input int y);
    return {5'(x), 5'(y)};
  endfunction

  task automatic pushWrite(input logic [9:0] a, input logic [1:0] d, input int lat);
    wrExp_t e;
    e.addr = a; e.data = d; e.lat = lat;
    wrQ.push_back(e);
  endtask

  task automatic pushResp(input logic [1:0] c, input int lat);
    respExp_t e;
    e.code = c; e.lat = lat;
    respQ.push_back(e);
  endtask

  // Offer one command from an idle DUT and record the accept cycle
  task automatic applyStimulus(input logic [1:0] op, input int x, input int y, input int len, input logic vert);
    @(negedge clk);
    checkOutput("ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_x     = 4'(x);
    bus.cmd_y     = 4'(y);
    bus.cmd_len   = 3'(len);
    bus.cmd_vert  = vert;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 acceptCycle = cycleNo - 1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("ready_busy", 32'(bus.cmd_ready), 32'd0);
  endtask

  task automatic waitResp(input int maxCycles);
    int n = 0;
    while (respQ.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_timeout", 32'(respQ.size()), 32'd0);
    checkOutput("writes_left", 32'(wrQ.size()), 32'd0);
  endtask

  task automatic doClear();
    for (int i = 0; i < 100; i++) pushWrite(addrOf(i % 10, i / 10), TILE_EMPTY, i + 1);
    pushResp(RESP_OK, 101);
    applyStimulus(OP_CLEAR, 0, 0, 0, 1'b0);
    waitResp(150);
    checkOutput("hit_after_clear", 32'(bus.hit_count), 32'd0);
  endtask

  task automatic placeOk(input int x, input int y, input int len, input logic vert);
    logic [9:0] a;
    for (int i = 0; i < len; i++) begin
      a = vert ? addrOf(x, y + i) : addrOf(x + i, y);
      pushWrite(a, TILE_SHIP, 2 * len + 1 + i);
      shipTiles.push_back(a);
    end
    pushResp(RESP_OK, 3 * len + 1);
    applyStimulus(OP_PLACE, x, y, len, vert);
    waitResp(40);
  endtask

  task automatic expectReject(input logic [1:0] op, input int x, input int y, input int len,
                              input logic vert, input int lat);
    pushResp(RESP_REJECT, lat);
    applyStimulus(op, x, y, len, vert);
    waitResp(40);
  endtask

  task automatic fireAt(input int x, input int y, input logic [1:0] code);
    if (code == RESP_HIT)  pushWrite(addrOf(x, y), TILE_HIT, 4);
    if (code == RESP_MISS) pushWrite(addrOf(x, y), TILE_MISS, 4);
    pushResp(code, (x > 9 || y > 9) ? 1 : 4);
    applyStimulus(OP_FIRE, x, y, 0, 1'b0);
    waitResp(20);
  endtask

  // Watchdog so a stuck DUT still terminates the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_len   = '0;
    bus.cmd_vert  = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_we", 32'(bus.ram_we), 32'd0);
    checkOutput("rst_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_code", 32'(bus.resp_code), 32'd0);
    checkOutput("rst_hit_count", 32'(bus.hit_count), 32'd0);
    checkOutput("rst_all_sunk", 32'(bus.all_sunk), 32'd0);
    rst_n = 1'b1;

    $display("[TB] CLEAR and PLACE checks");
    doClear();
    placeOk(2, 3, 4, 1'b0);
    expectReject(OP_PLACE, 4, 0, 5, 1'b1, 9);
    expectReject(OP_PLACE, 7, 0, 4, 1'b0, 1);
    expectReject(OP_PLACE, 0, 0, 6, 1'b0, 1);
    expectReject(OP_PLACE, 0, 0, 1, 1'b0, 1);
    expectReject(OP_PLACE, 10, 0, 2, 1'b0, 1);
    expectReject(OP_PLACE, 0, 8, 3, 1'b1, 1);
    expectReject(OP_RSVD, 1, 1, 2, 1'b0, 1);
    placeOk(6, 0, 4, 1'b0);

    $display("[TB] FIRE checks");
    fireAt(3, 3, RESP_HIT);
    checkOutput("hit_one", 32'(bus.hit_count), 32'd1);
    fireAt(3, 3, RESP_REJECT);
    fireAt(9, 9, RESP_MISS);
    fireAt(9, 9, RESP_REJECT);
    fireAt(12, 0, RESP_REJECT);
    checkOutput("hit_still_one", 32'(bus.hit_count), 32'd1);

    $display("[TB] Full fleet");
    doClear();
    shipTiles.delete();
    placeOk(0, 0, 5, 1'b0);
    placeOk(0, 2, 4, 1'b1);
    placeOk(5, 5, 3, 1'b0);
    placeOk(9, 0, 3, 1'b1);
    placeOk(3, 8, 2, 1'b0);
    k = 0;
    foreach (shipTiles[i]) begin
      fireAt(int'(shipTiles[i][9:5]), int'(shipTiles[i][4:0]), RESP_HIT);
      k++;
      checkOutput("fleet_hits", 32'(bus.hit_count), 32'(k));
      checkOutput("fleet_sunk", 32'(bus.all_sunk), (k == SHIP_CELLS) ? 32'd1 : 32'd0);
    end
    placeOk(6, 8, 2, 1'b0);
    fireAt(6, 8, RESP_HIT);
    checkOutput("hit_saturated", 32'(bus.hit_count), 32'd17);
    checkOutput("sunk_saturated", 32'(bus.all_sunk), 32'd1);

    $display("[TB] Reset during CLEAR");
    for (int i = 0; i < 49; i++) pushWrite(addrOf(i % 10, i / 10), TILE_EMPTY, i + 1);
    applyStimulus(OP_CLEAR, 0, 0, 0, 1'b0);
    for (int n = 0; n < 200 && (cycleNo - acceptCycle) < 50; n++) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we", 32'(bus.ram_we), 32'd0);
    checkOutput("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("midrst_writes_left", 32'(wrQ.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_resp", 32'(respQ.size()), 32'd0);
    checkOutput("midrst_hits", 32'(bus.hit_count), 32'd0);
    fireAt(7, 8, RESP_HIT);
    checkOutput("post_rst_hits", 32'(bus.hit_count), 32'd1);
    fireAt(0, 0, RESP_MISS);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/board_updater.md
# board_updater

Write-side engine for one player's 10x10 board RAM; the tile renderer reads the same RAM on the other port. Accepts CLEAR, PLACE and FIRE commands over a valid/ready handshake. It performs read-check-write sequences on tile codes and returns one response code per command. It also tracks hits scored against the board for game-over detection.

## Interface
- SHIP_CELLS, 17: total ship tiles per fleet (5+4+3+3+2); `all_sunk` threshold.
- BOARD_DIM, 10: board width and height in tiles.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=CLEAR, 1=PLACE, 2=FIRE, 3=reserved (rejected)
- cmd_x, cmd_y  in  4 each  tile column/row; same format as renderer cursor nibbles
- cmd_len  in  3  ship length; PLACE only
- cmd_vert  in  1  PLACE orientation: 1 = +y, 0 = +x
- ram_addr  out  10  {x[4:0], y[4:0]}, registered
- ram_we  out  1  write strobe, registered
- ram_wdata  out  2  tile code, registered
- ram_rdata  in  2  tile code; valid one cycle after `ram_addr` is sampled
- resp_valid  out  1  one-cycle pulse per accepted command
- resp_code  out  2  0=OK, 1=HIT, 2=MISS, 3=REJECT; held until next response
- hit_count  out  5  hits on this board, saturating at SHIP_CELLS
- all_sunk  out  1  hit_count == SHIP_CELLS

## Operation
- Tile codes: EMPTY=0, HIT=1, MISS=2, SHIP=3.
- Reset values: state IDLE; cmd_ready 1; ram_we 0; ram_addr 0; ram_wdata 0; resp_valid 0; resp_code 0; hit_count 0. RAM contents are untouched; software issues CLEAR.
- Accept happens on a cycle with cmd_valid && cmd_ready. All cmd_* fields are latched on accept. Offers while busy are not seen; the initiator holds them.
- States: IDLE, CLR, CHK_RD, CHK_EV, PL_WR, F_RD, F_WAIT, F_EV, RESP.
- CLEAR: CLR writes EMPTY to all 100 tiles, y outer 0..9 and x inner 0..9, one per cycle. Then OK. Also zeroes hit_count.
- PLACE, up-front checks: REJECT with no RAM access if any of these hold:
  - cmd_len outside 2..5
  - x or y > 9
  - end coordinate (start + len - 1) > 9 on the growth axis
- PLACE, overlap check: CHK_RD/CHK_EV alternate, 2 cycles per tile. Any non-EMPTY tile gives REJECT with no writes.
- PLACE, write: otherwise PL_WR writes SHIP to each tile, 1 per cycle. Then OK.
- FIRE: x or y > 9 gives REJECT. Otherwise the tile is read, then:
  - SHIP: write HIT, respond HIT, hit_count += 1 (saturating).
  - EMPTY: write MISS, respond MISS.
  - HIT or MISS: no write, REJECT.
- Op 3 gives REJECT.
- Coordinate arithmetic is 5-bit, so end-coordinate overflow cannot wrap.

## Timing
- cmd_ready drops the cycle after accept. It returns high the cycle after resp_valid.
- Immediate REJECT: resp_valid 1 cycle after accept.
- FIRE, accept at cycle 0:
  - ram_addr valid from cycle 1
  - rdata evaluated in cycle 3 (F_EV)
  - ram_we/wdata high in cycle 4, same cycle as resp_valid
  - hit_count updates in cycle 4
- PLACE length L, accepted: resp_valid at cycle 2L+L+1 after accept; ram_we high L consecutive cycles. Overlap REJECT is reported right after the offending CHK_EV.
- CLEAR: ram_we high cycles 1..100; resp_valid cycle 101.
- ram_we is never high in a cycle where a read result is being evaluated.
- Async reset mid-operation: ram_we drops immediately. Any partial PLACE or CLEAR is left in RAM with no response.

## Structure
- Shared `battleship_pkg`: tile codes, op codes, response codes, BOARD_DIM, SHIP_CELLS. The renderer adopts the same tile constants.
- One sub-module is natural: `board_coord_step`. It holds the x/y cursor with a step direction, produces the 10-bit RAM address, and provides last-tile detect. It is shared by CLR, CHK and PL_WR.

## Test plan
- Reset, then CLEAR -> 100 writes of 0 at addresses {x,y} in y-major order; resp OK at cycle 101; hit_count=0.
- PLACE x=2, y=3, len=4, vert=0 on an empty board -> tiles (2..5,3)=SHIP; resp OK at cycle 13. Repeat PLACE x=4, y=0, len=5, vert=1 -> overlap at (4,3), REJECT, no ram_we.
- PLACE x=7, y=0, len=4, vert=0 -> REJECT at cycle 1. Same for len=6 and len=1.
- FIRE (3,3) on SHIP -> write HIT at cycle 4; resp HIT; hit_count 0→1. FIRE (3,3) again -> REJECT, no write. FIRE (9,9) on EMPTY -> MISS written.
- Place a full fleet, then fire all 17 ship tiles -> all_sunk rises on the 17th HIT response. An 18th FIRE leaves hit_count at 17.
- Assert rst low during CLEAR at cycle 50 -> ram_we 0 and cmd_ready 1 asynchronously; no resp_valid. A subsequent FIRE operates normally.
